// File: rtl/lcd_init_rom.sv
// ---------------------------------------------------------------------------
// LcdInitRom (module lcd_init_rom)
//
// Purpose:
//   Two independent one-cycle-latency read-only tables that hold the ST7735
//   160x80 power-up sequence. The command table holds opcodes. The parameter
//   table holds their parameter bytes in the same order, followed by the
//   fill colour at address 67. The sequencer owns all pointers and timing.
//   This block only stores bytes and flags when a read result is valid.
//
// Ports:
//   clk              system clock, rising-edge
//   rst_n            asynchronous active-low reset
//   cmd_rd_en        command-table read request
//   cmd_rd_addr      command-table address (0..31; 21..31 read as NOP 00)
//   cmd_data_out     command byte, held while cmd_rd_en is low
//   cmd_valid_out    high the cycle after each cmd_rd_en cycle
//   param_rd_en      parameter-table read request
//   param_rd_addr    parameter-table address (0..127; 68..127 read 00)
//   param_data_out   parameter byte, held while param_rd_en is low
//   param_valid_out  high the cycle after each param_rd_en cycle
//   addr_err         (only with LCD_ROM_RANGE_ERR_EN) registered flag for
//                    a read outside the populated part of either table
//
// Configuration macro: LCD_ROM_RANGE_ERR_EN
// ---------------------------------------------------------------------------
module lcd_init_rom #(
    parameter logic [7:0] PIXEL_COLOR = 8'h1F,
    parameter logic [7:0] MADCTL_VAL  = 8'h78
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_rd_en,
    input  logic [4:0] cmd_rd_addr,
    output logic [7:0] cmd_data_out,
    output logic       cmd_valid_out,
    input  logic       param_rd_en,
    input  logic [6:0] param_rd_addr,
    output logic [7:0] param_data_out,
    output logic       param_valid_out
`ifdef LCD_ROM_RANGE_ERR_EN
    ,
    output logic       addr_err
`endif
);

    // Command opcodes in issue order. Unused slots return NOP (00).
    function automatic logic [7:0] cmdRom(input logic [4:0] addr);
        logic [7:0] value;
        case (addr)
            5'd0:    value = 8'h11;
            5'd1:    value = 8'hB1;
            5'd2:    value = 8'hB2;
            5'd3:    value = 8'hB3;
            5'd4:    value = 8'hB4;
            5'd5:    value = 8'hC0;
            5'd6:    value = 8'hC1;
            5'd7:    value = 8'hC2;
            5'd8:    value = 8'hC3;
            5'd9:    value = 8'hC4;
            5'd10:   value = 8'hC5;
            5'd11:   value = 8'hE0;
            5'd12:   value = 8'hE1;
            5'd13:   value = 8'hFC;
            5'd14:   value = 8'h3A;
            5'd15:   value = 8'h36;
            5'd16:   value = 8'h2A;
            5'd17:   value = 8'h2B;
            5'd18:   value = 8'h21;
            5'd19:   value = 8'h29;
            5'd20:   value = 8'h2C;
            default: value = 8'h00;
        endcase
        return value;
    endfunction

    // Parameter bytes, packed back-to-back in command order. Commands that
    // take no parameters (SLPOUT, INVON, DISPON, RAMWR) have no entries here;
    // RAMWR streams the single colour byte at 67 repeatedly.
    function automatic logic [7:0] paramRom(input logic [6:0] addr);
        logic [7:0] value;
        case (addr)
            // FRMCTR1 / FRMCTR2 / FRMCTR3
            7'd0, 7'd3, 7'd6, 7'd9:    value = 8'h01;
            7'd1, 7'd4, 7'd7, 7'd10:   value = 8'h2C;
            7'd2, 7'd5, 7'd8, 7'd11:   value = 8'h2D;
            // INVCTR, PWCTR1..5, VMCTR1
            7'd12:   value = 8'h07;
            7'd13:   value = 8'hA2;
            7'd14:   value = 8'h02;
            7'd15:   value = 8'h84;
            7'd16:   value = 8'hC5;
            7'd17:   value = 8'h0A;
            7'd18:   value = 8'h00;
            7'd19:   value = 8'h8A;
            7'd20:   value = 8'h2A;
            7'd21:   value = 8'h8A;
            7'd22:   value = 8'hEE;
            7'd23:   value = 8'h0E;
            // GMCTRP1
            7'd24:   value = 8'h02;
            7'd25:   value = 8'h1C;
            7'd26:   value = 8'h07;
            7'd27:   value = 8'h12;
            7'd28:   value = 8'h37;
            7'd29:   value = 8'h32;
            7'd30:   value = 8'h29;
            7'd31:   value = 8'h2D;
            7'd32:   value = 8'h29;
            7'd33:   value = 8'h25;
            7'd34:   value = 8'h2B;
            7'd35:   value = 8'h39;
            7'd36:   value = 8'h00;
            7'd37:   value = 8'h01;
            7'd38:   value = 8'h03;
            7'd39:   value = 8'h10;
            // GMCTRN1
            7'd40:   value = 8'h03;
            7'd41:   value = 8'h1D;
            7'd42:   value = 8'h07;
            7'd43:   value = 8'h06;
            7'd44:   value = 8'h2E;
            7'd45:   value = 8'h2C;
            7'd46:   value = 8'h29;
            7'd47:   value = 8'h2D;
            7'd48:   value = 8'h2E;
            7'd49:   value = 8'h2E;
            7'd50:   value = 8'h37;
            7'd51:   value = 8'h3F;
            7'd52:   value = 8'h00;
            7'd53:   value = 8'h00;
            7'd54:   value = 8'h02;
            7'd55:   value = 8'h10;
            // PWCTR6, COLMOD (16-bit), MADCTL
            7'd56:   value = 8'h01;
            7'd57:   value = 8'h05;
            7'd58:   value = MADCTL_VAL;
            // CASET 1..160, RASET 26..105 (80-row window in the 132x162 RAM)
            7'd59:   value = 8'h00;
            7'd60:   value = 8'h01;
            7'd61:   value = 8'h00;
            7'd62:   value = 8'hA0;
            7'd63:   value = 8'h00;
            7'd64:   value = 8'h1A;
            7'd65:   value = 8'h00;
            7'd66:   value = 8'h69;
            // Fill colour, sent as both halves of every RGB565 pixel
            7'd67:   value = PIXEL_COLOR;
            default: value = 8'h00;
        endcase
        return value;
    endfunction

    logic [7:0] cmd_data_q,   cmd_data_d;
    logic       cmd_valid_q;
    logic [7:0] param_data_q, param_data_d;
    logic       param_valid_q;

    // Data only updates on a read; otherwise it holds so the sequencer can
    // keep comparing the last byte after dropping the request.
    always_comb begin
        cmd_data_d   = cmd_data_q;
        param_data_d = param_data_q;
        if (cmd_rd_en) begin
            cmd_data_d = cmdRom(cmd_rd_addr);
        end
        if (param_rd_en) begin
            param_data_d = paramRom(param_rd_addr);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_data_q    <= 8'h00;
            cmd_valid_q   <= 1'b0;
            param_data_q  <= 8'h00;
            param_valid_q <= 1'b0;
        end else begin
            cmd_data_q    <= cmd_data_d;
            cmd_valid_q   <= cmd_rd_en;
            param_data_q  <= param_data_d;
            param_valid_q <= param_rd_en;
        end
    end

    assign cmd_data_out    = cmd_data_q;
    assign cmd_valid_out   = cmd_valid_q;
    assign param_data_out  = param_data_q;
    assign param_valid_out = param_valid_q;

`ifdef LCD_ROM_RANGE_ERR_EN
    logic addr_err_q, addr_err_d;

    // Flags reads past the last populated entry of either table.
    always_comb begin
        addr_err_d = (cmd_rd_en   && (cmd_rd_addr   > 5'd20)) ||
                     (param_rd_en && (param_rd_addr > 7'd67));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_err_q <= 1'b0;
        end else begin
            addr_err_q <= addr_err_d;
        end
    end

    assign addr_err = addr_err_q;
`endif

endmodule

// File: tb/tb_lcd_init_rom.sv
// ---------------------------------------------------------------------------
// Testbench for lcd_init_rom.
// Two instances share all inputs: dut uses the default fill colour (1F),
// dut2 is built with PIXEL_COLOR = F8. Inputs change on the falling edge and
// outputs are sampled on the following falling edge.
// ---------------------------------------------------------------------------
module tb_lcd_init_rom;

    logic       clk;
    logic       rst_n;
    logic       cmd_rd_en;
    logic [4:0] cmd_rd_addr;
    logic [7:0] cmd_data_out,   cmd_data_out2;
    logic       cmd_valid_out,  cmd_valid_out2;
    logic       param_rd_en;
    logic [6:0] param_rd_addr;
    logic [7:0] param_data_out, param_data_out2;
    logic       param_valid_out, param_valid_out2;
`ifdef LCD_ROM_RANGE_ERR_EN
    logic       addr_err, addr_err2;
`endif

    int assertCount = 0;
    int failCount   = 0;

    lcd_init_rom dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cmd_rd_en       (cmd_rd_en),
        .cmd_rd_addr     (cmd_rd_addr),
        .cmd_data_out    (cmd_data_out),
        .cmd_valid_out   (cmd_valid_out),
        .param_rd_en     (param_rd_en),
        .param_rd_addr   (param_rd_addr),
        .param_data_out  (param_data_out),
        .param_valid_out (param_valid_out)
`ifdef LCD_ROM_RANGE_ERR_EN
        ,
        .addr_err        (addr_err)
`endif
    );

    lcd_init_rom #(.PIXEL_COLOR(8'hF8)) dut2 (
        .clk             (clk),
        .rst_n           (rst_n),
        .cmd_rd_en       (cmd_rd_en),
        .cmd_rd_addr     (cmd_rd_addr),
        .cmd_data_out    (cmd_data_out2),
        .cmd_valid_out   (cmd_valid_out2),
        .param_rd_en     (param_rd_en),
        .param_rd_addr   (param_rd_addr),
        .param_data_out  (param_data_out2),
        .param_valid_out (param_valid_out2)
`ifdef LCD_ROM_RANGE_ERR_EN
        ,
        .addr_err        (addr_err2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [7:0] actual,
                               input logic [7:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %02h, expected %02h", tag, actual, expected);
        end
    endtask

    // Present one set of read requests on the next falling edge.
    task automatic applyStimulus(input logic cEn, input logic [4:0] cAddr,
                                 input logic pEn, input logic [6:0] pAddr);
        @(negedge clk);
        cmd_rd_en     = cEn;
        cmd_rd_addr   = cAddr;
        param_rd_en   = pEn;
        param_rd_addr = pAddr;
    endtask

    logic [7:0] cmdExp [0:31];
    logic [7:0] gmpExp [0:15];
    logic [6:0] pVecAddr [0:19];
    logic [7:0] pVecData [0:19];

    initial begin
        cmdExp = '{8'h11, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hC0,
                   8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hE0,
                   8'hE1, 8'hFC, 8'h3A, 8'h36, 8'h2A, 8'h2B,
                   8'h21, 8'h29, 8'h2C,
                   8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                   8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        gmpExp = '{8'h02, 8'h1C, 8'h07, 8'h12, 8'h37, 8'h32, 8'h29, 8'h2D,
                   8'h29, 8'h25, 8'h2B, 8'h39, 8'h00, 8'h01, 8'h03, 8'h10};
        pVecAddr = '{7'd0,  7'd11, 7'd12, 7'd15, 7'd16, 7'd18, 7'd19,
                     7'd22, 7'd23, 7'd40, 7'd51, 7'd55, 7'd56, 7'd57,
                     7'd58, 7'd62, 7'd64, 7'd66, 7'd68, 7'd127};
        pVecData = '{8'h01, 8'h2D, 8'h07, 8'h84, 8'hC5, 8'h00, 8'h8A,
                     8'hEE, 8'h0E, 8'h03, 8'h3F, 8'h10, 8'h01, 8'h05,
                     8'h78, 8'hA0, 8'h1A, 8'h69, 8'h00, 8'h00};

        cmd_rd_en = 1'b0; cmd_rd_addr = '0;
        param_rd_en = 1'b0; param_rd_addr = '0;
        rst_n = 1'b1;

        // Reset asserted between edges takes effect immediately.
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst cmd_data",    cmd_data_out,           8'h00);
        checkOutput("rst cmd_valid",   {7'd0, cmd_valid_out},  8'h00);
        checkOutput("rst param_data",  param_data_out,         8'h00);
        checkOutput("rst param_valid", {7'd0, param_valid_out}, 8'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post-rst cmd_valid",   {7'd0, cmd_valid_out},   8'h00);
        checkOutput("post-rst param_valid", {7'd0, param_valid_out}, 8'h00);
        checkOutput("post-rst cmd_data",    cmd_data_out,            8'h00);

        // Command sweep, one single-cycle read per address.
        for (int a = 0; a < 32; a++) begin
            applyStimulus(1'b1, 5'(a), 1'b0, 7'd0);
            applyStimulus(1'b0, 5'(a), 1'b0, 7'd0);
            checkOutput($sformatf("cmd[%0d] data", a), cmd_data_out, cmdExp[a]);
            checkOutput($sformatf("cmd[%0d] valid", a), {7'd0, cmd_valid_out}, 8'h01);
            @(negedge clk);
            checkOutput($sformatf("cmd[%0d] valid drop", a), {7'd0, cmd_valid_out}, 8'h00);
        end

        // Parameter spot checks including boundaries and MADCTL.
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 5'd0, 1'b1, pVecAddr[i]);
            applyStimulus(1'b0, 5'd0, 1'b0, 7'd0);
            checkOutput($sformatf("param[%0d]", pVecAddr[i]), param_data_out, pVecData[i]);
            checkOutput($sformatf("param[%0d] valid", pVecAddr[i]),
                        {7'd0, param_valid_out}, 8'h01);
        end

        // Hold: data stays after rd_en drops even though the address moves.
        applyStimulus(1'b0, 5'd0, 1'b1, 7'd13);
        applyStimulus(1'b0, 5'd0, 1'b0, 7'd40);
        checkOutput("hold first", param_data_out, 8'hA2);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checkOutput($sformatf("hold data c%0d", c), param_data_out, 8'hA2);
            checkOutput($sformatf("hold valid c%0d", c), {7'd0, param_valid_out}, 8'h00);
        end

        // Streaming through GMCTRP1 with rd_en held high.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 5'd0, 1'b1, 7'(24 + i));
            if (i > 0) begin
                checkOutput($sformatf("stream[%0d]", 24 + i - 1), param_data_out, gmpExp[i-1]);
                checkOutput($sformatf("stream valid %0d", i), {7'd0, param_valid_out}, 8'h01);
            end
        end
        applyStimulus(1'b0, 5'd0, 1'b0, 7'd0);
        checkOutput("stream last", param_data_out, 8'h10);

        // Concurrent reads on both ports, both fill-colour builds.
        applyStimulus(1'b1, 5'd19, 1'b1, 7'd67);
        applyStimulus(1'b0, 5'd0, 1'b0, 7'd0);
        checkOutput("conc cmd",         cmd_data_out,            8'h29);
        checkOutput("conc param",       param_data_out,          8'h1F);
        checkOutput("conc cmd valid",   {7'd0, cmd_valid_out},   8'h01);
        checkOutput("conc param valid", {7'd0, param_valid_out}, 8'h01);
        checkOutput("conc F8 param",    param_data_out2,         8'hF8);
        checkOutput("conc F8 cmd",      cmd_data_out2,           8'h29);

        // Reset during a valid cycle clears outputs without waiting for clk.
        applyStimulus(1'b1, 5'd1, 1'b1, 7'd16);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst cmd_data",    cmd_data_out,            8'h00);
        checkOutput("midrst cmd_valid",   {7'd0, cmd_valid_out},   8'h00);
        checkOutput("midrst param_data",  param_data_out,          8'h00);
        checkOutput("midrst param_valid", {7'd0, param_valid_out}, 8'h00);
        applyStimulus(1'b0, 5'd0, 1'b0, 7'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("after midrst cmd_data", cmd_data_out,          8'h00);
        checkOutput("after midrst valid",    {7'd0, cmd_valid_out}, 8'h00);

`ifdef LCD_ROM_RANGE_ERR_EN
        applyStimulus(1'b0, 5'd0, 1'b1, 7'd68);
        applyStimulus(1'b0, 5'd0, 1'b0, 7'd0);
        checkOutput("err p68",      {7'd0, addr_err}, 8'h01);
        checkOutput("err p68 data", param_data_out,   8'h00);
        @(negedge clk);
        checkOutput("err clears",   {7'd0, addr_err}, 8'h00);
        applyStimulus(1'b0, 5'd0, 1'b1, 7'd67);
        applyStimulus(1'b1, 5'd20, 1'b0, 7'd0);
        checkOutput("err p67",      {7'd0, addr_err}, 8'h00);
        applyStimulus(1'b1, 5'd21, 1'b0, 7'd0);
        checkOutput("err c20",      {7'd0, addr_err}, 8'h00);
        applyStimulus(1'b0, 5'd0, 1'b0, 7'd0);
        checkOutput("err c21",      {7'd0, addr_err}, 8'h01);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertCount, failCount);
        $finish;
    end

endmodule
